result_deskewer: RTL and testbench

RESULT_DESKEWER -- requirements
Module: result_deskewer

---
 rtl/systolic_pkg.sv | 31 +++
 rtl/result_deskewer_fifo.sv | 75 +++++++
 rtl/result_deskewer.sv | 172 +++++++++++++++++
 tb/tb_result_deskewer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared types and sizing helpers for the systolic-array result path.
//
//   Contents:
//     DEF_*          default configuration (2x2 array, 32-bit sums, 4-row FIFO)
//     word_t         one column sum at the default width
//     row_vec_t      one result row (DEF_MATRIX_SIZE words, index = column)
//     ptr_width()    bits needed for a FIFO pointer wrapping modulo depth
//     count_width()  bits needed for a count that ranges 0..depth inclusive
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DEF_MATRIX_SIZE = 2;
  localparam int DEF_DATA_SIZE   = 32;
  localparam int DEF_FIFO_DEPTH  = 4;

  typedef logic [DEF_DATA_SIZE-1:0] word_t;
  typedef word_t [DEF_MATRIX_SIZE-1:0] row_vec_t;

  // Pointer into a power-of-two buffer; natural overflow gives the wrap.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must be able to hold the value 'depth' itself (full).
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/result_deskewer_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//   Synchronous FIFO with occupancy count, used to buffer aligned result rows.
//   DEPTH must be a power of two (pointers wrap by natural overflow).
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset (clears pointers and count)
//     push       write request; accepted when not full, or when full and a
//                pop is accepted in the same cycle
//     push_data  data written on an accepted push
//     pop        read request; accepted only when not empty
//     pop_data   entry at the read pointer (valid while not empty)
//     count      number of stored entries, 0..DEPTH
//     empty      count == 0
//
//   A push into an empty FIFO becomes visible on the following cycle; there
//   is no fall-through path from push_data to pop_data.
// -----------------------------------------------------------------------------
module result_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a write when a read frees a slot this cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents are only observed behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/result_deskewer.sv
// -----------------------------------------------------------------------------
// result_deskewer
//   Re-aligns the skewed column sums leaving an N x N systolic array into
//   whole rows, tags the last row of each matrix, and buffers rows for a
//   valid/ready consumer.
//
//   Ports:
//     clk           rising-edge clock
//     reset         asynchronous active-low reset
//     sum_valid_in  column 0 of a new row is on sum_in this cycle
//     sum_in        column sums, column j in bits [j*DATA_SIZE +: DATA_SIZE];
//                   column j arrives j cycles after column 0
//     sum_ready     credit available: buffered + in-flight rows < FIFO_DEPTH
//     row_valid     an aligned row is on row_out
//     row_ready     consumer accepts row_out
//     row_out       deskewed row, column j at index j (0 when row_valid is low)
//     row_last      row_out is row N-1 of a matrix (0 when row_valid is low)
//     overflow      sticky: an aligned row found the buffer full and was lost
//
//   Handshake: a row moves to the consumer on every rising edge where
//   row_valid and row_ready are both high; while row_valid is high and
//   row_ready is low, row_out and row_last hold. sum_ready is advisory: a row
//   start is always taken, and if it reaches the buffer while full with no
//   pop in that cycle it is dropped.
//
//   Build option: define RESULT_DESKEW_OVF_EN to implement drop detection and
//   the sticky overflow flag; otherwise overflow is tied to 0.
//
//   Latency: with the buffer empty, a row started in cycle t is written on
//   the edge ending cycle t+N-1 and row_valid rises in cycle t+N.
// -----------------------------------------------------------------------------
module result_deskewer
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sum_valid_in,
  input  logic [DATA_SIZE*MATRIX_SIZE-1:0] sum_in,
  output logic                             sum_ready,
  output logic                             row_valid,
  input  logic                             row_ready,
  output logic [DATA_SIZE*MATRIX_SIZE-1:0] row_out,
  output logic                             row_last,
  output logic                             overflow
);

  localparam int N     = MATRIX_SIZE;
  localparam int ROW_W = DATA_SIZE * N;
  localparam int CW    = count_width(FIFO_DEPTH);
  localparam int SW    = count_width(FIFO_DEPTH + N);
  localparam int VW    = (N > 1) ? N - 1 : 1;
  localparam int RCW   = (N > 1) ? $clog2(N) : 1;

  logic [ROW_W-1:0] aligned_row;
  logic             aligned_valid;
  logic [VW-1:0]    vld_sr;
  logic [SW-1:0]    in_flight;
  logic [SW-1:0]    credits;
  logic [RCW-1:0]   row_cnt;
  logic             aligned_last;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [ROW_W:0]   fifo_rd_data;

  // ---------------------------------------------------------------------------
  // Column delay lines: column j waits N-1-j cycles so every column of a row
  // lines up with the undelayed last column.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned_row[j*DATA_SIZE +: DATA_SIZE] = sum_in[j*DATA_SIZE +: DATA_SIZE];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] taps [D];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < D; k++) taps[k] <= '0;
        end else begin
          taps[0] <= sum_in[j*DATA_SIZE +: DATA_SIZE];
          for (int k = 1; k < D; k++) taps[k] <= taps[k-1];
        end
      end
      assign aligned_row[j*DATA_SIZE +: DATA_SIZE] = taps[D-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Valid shift register. Each set bit is a row already started but not yet
  // written into the buffer; those rows hold a credit.
  // ---------------------------------------------------------------------------
  if (N > 1) begin : g_vsr
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_sr <= '0;
      else        vld_sr <= (vld_sr << 1) | VW'(sum_valid_in);
    end
    assign aligned_valid = vld_sr[VW-1];
  end else begin : g_no_vsr
    assign vld_sr        = '0;
    assign aligned_valid = sum_valid_in;
  end

  always_comb begin
    in_flight = '0;
    for (int k = 0; k < VW; k++) in_flight = in_flight + SW'(vld_sr[k]);
  end

  assign credits   = SW'(fifo_count) + in_flight;
  assign sum_ready = (credits < SW'(FIFO_DEPTH));

  // ---------------------------------------------------------------------------
  // Row position within the current matrix. Dropped rows still advance it so
  // later rows keep their correct row_last tag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
    end else if (aligned_valid) begin
      row_cnt <= (row_cnt == RCW'(N - 1)) ? '0 : row_cnt + RCW'(1);
    end
  end

  assign aligned_last = (row_cnt == RCW'(N - 1));

  // ---------------------------------------------------------------------------
  // Row buffer: each entry is {row_last, row}.
  // ---------------------------------------------------------------------------
  result_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (aligned_valid),
    .push_data ({aligned_last, aligned_row}),
    .pop       (row_ready),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign row_valid = ~fifo_empty;
  // Gate the storage read so stale buffer contents never reach the outputs.
  assign row_out   = row_valid ? fifo_rd_data[ROW_W-1:0] : '0;
  assign row_last  = row_valid & fifo_rd_data[ROW_W];

  // ---------------------------------------------------------------------------
  // Drop detection
  // ---------------------------------------------------------------------------
`ifdef RESULT_DESKEW_OVF_EN
  logic fifo_full;
  logic row_drop;
  logic overflow_q;

  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  // Full with a simultaneous pop is a legal push, not a drop.
  assign row_drop  = aligned_valid & fifo_full & ~(row_valid & row_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        overflow_q <= 1'b0;
    else if (row_drop) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_result_deskewer.sv
// -----------------------------------------------------------------------------
// tb_result_deskewer
//   Directed bench for result_deskewer at N=2, 32-bit sums, 4-row buffer.
//   A row-level reference model (queue of rows, credit arithmetic, matrix row
//   index) is compared against the DUT every cycle out of reset; directed
//   sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_result_deskewer;
  import systolic_pkg::*;

  localparam int N     = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int RW    = N * DW;

`ifdef RESULT_DESKEW_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          sum_valid_in = 1'b0;
  logic [RW-1:0] sum_in       = '0;
  logic          row_ready    = 1'b0;
  logic          sum_ready;
  logic          row_valid;
  logic [RW-1:0] row_out;
  logic          row_last;
  logic          overflow;

  always #5 clk = ~clk;

  result_deskewer #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (DW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sum_valid_in (sum_valid_in),
    .sum_in       (sum_in),
    .sum_ready    (sum_ready),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_out      (row_out),
    .row_last     (row_last),
    .overflow     (overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [RW:0]   exp_q[$];     // {row_last, row} in delivery order
  logic [RW-1:0] hist_row [N]; // hist_*[k]: row started k cycles ago
  logic          hist_v   [N];
  bit            model_ovf;
  int            model_idx;
  bit            m_pop;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Row-level model: pop first, then an arriving row is kept if a slot is free.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      model_ovf = 1'b0;
      model_idx = 0;
    end else begin
      m_pop = (exp_q.size() != 0) && row_ready;
      if (m_pop) void'(exp_q.pop_front());
      if (hist_v[N-1]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({(model_idx == N - 1), hist_row[N-1]});
        else if (OVF_EN)          model_ovf = 1'b1;
        model_idx = (model_idx + 1) % N;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      int pending;
      pending = 0;
      for (int k = 1; k < N; k++) if (hist_v[k]) pending++;
      check("row_valid", RW'(row_valid), RW'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("row_out", row_out, exp_q[0][RW-1:0]);
        check("row_last", RW'(row_last), RW'(exp_q[0][RW]));
      end
      check("sum_ready", RW'(sum_ready), RW'((exp_q.size() + pending) < DEPTH));
      check("overflow", RW'(overflow), RW'(model_ovf));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1; each step spans exactly one cycle)
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    for (int k = N - 1; k > 0; k--) begin
      hist_v[k]   = hist_v[k-1];
      hist_row[k] = hist_row[k-1];
    end
    hist_v[0]   = v;
    hist_row[0] = {c1, c0};
    sum_valid_in = v;
    for (int j = 0; j < N; j++)
      sum_in[j*DW +: DW] = hist_v[j] ? hist_row[j][j*DW +: DW] : DW'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    sum_valid_in = 1'b0;
    row_ready    = 1'b0;
    for (int k = 0; k < N; k++) begin
      hist_v[k]   = 1'b0;
      hist_row[k] = '0;
    end
    #1;
    check("rst_row_valid", RW'(row_valid), '0);
    check("rst_row_last", RW'(row_last), '0);
    check("rst_row_out", row_out, '0);
    check("rst_overflow", RW'(overflow), '0);
    check("rst_sum_ready", RW'(sum_ready), RW'(1));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  initial begin
    int pushed;

    for (int k = 0; k < N; k++) begin
      hist_v[k]   = 1'b0;
      hist_row[k] = '0;
    end
    #2;

    // Single row {5,7}: visible in cycle 2, not earlier.
    do_reset();
    row_ready = 1'b1;
    step(1'b1, 32'd5, 32'd7);
    check("single_early", RW'(row_valid), '0);
    step(1'b0, '0, '0);
    check("single_valid", RW'(row_valid), RW'(1));
    check("single_row", row_out, 64'h0000_0007_0000_0005);
    check("single_last", RW'(row_last), '0);
    idle(3);

    // Framing: {1,2} last=0, {3,4} last=1, {10,20} wraps to last=0.
    do_reset();
    row_ready = 1'b1;
    step(1'b1, 32'd1, 32'd2);
    step(1'b1, 32'd3, 32'd4);
    check("frame0_row", row_out, 64'h0000_0002_0000_0001);
    check("frame0_last", RW'(row_last), '0);
    step(1'b1, 32'd10, 32'd20);
    check("frame1_row", row_out, 64'h0000_0004_0000_0003);
    check("frame1_last", RW'(row_last), RW'(1));
    step(1'b0, '0, '0);
    check("frame2_row", row_out, 64'h0000_0014_0000_000a);
    check("frame2_last", RW'(row_last), '0);
    idle(3);

    // Backpressure: push only while credits remain; exactly 4 fit.
    do_reset();
    row_ready = 1'b0;
    pushed = 0;
    for (int i = 0; i < 10 && sum_ready; i++) begin
      step(1'b1, DW'(100 + i), DW'(200 + i));
      pushed++;
    end
    check("bp_credits", RW'(pushed), RW'(DEPTH));
    idle(3);
    check("bp_sum_ready", RW'(sum_ready), '0);
    check("bp_hold_row", row_out, {32'd200, 32'd100});
    row_ready = 1'b1;
    idle(6);
    check("bp_drained", RW'(row_valid), '0);

    // Forced overflow: 5th row arrives while full and stalled.
    do_reset();
    row_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, DW'(300 + i), DW'(400 + i));
    idle(2);
    check("ovf_flag", RW'(overflow), RW'(OVF_EN));
    check("ovf_first_row", row_out, {32'd400, 32'd300});
    idle(2);
    check("ovf_sticky", RW'(overflow), RW'(OVF_EN));
    row_ready = 1'b1;
    idle(6);
    check("ovf_drained", RW'(row_valid), '0);
    check("ovf_sticky_drain", RW'(overflow), RW'(OVF_EN));

    // Full push + pop: 5th row lands in the same cycle as a pop.
    do_reset();
    row_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, DW'(500 + i), DW'(600 + i));
    row_ready = 1'b1;
    step(1'b0, '0, '0);
    row_ready = 1'b0;
    check("pp_still_full", RW'(sum_ready), '0);
    check("pp_no_overflow", RW'(overflow), '0);
    check("pp_head", row_out, {32'd601, 32'd501});
    idle(1);
    row_ready = 1'b1;
    idle(6);
    check("pp_drained", RW'(row_valid), '0);

    // Mid-operation reset: 2 buffered, 1 in flight.
    do_reset();
    row_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, DW'(700 + i), DW'(800 + i));
    do_reset();
    row_ready = 1'b1;
    idle(5);
    check("mr_no_stale", RW'(row_valid), '0);
    check("mr_sum_ready", RW'(sum_ready), RW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always ends with a summary.
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout: got no end of sequence, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
